// File: rtl/mem_pkg.sv
// mem_pkg: memory-port op codes and arbiter state encoding shared across the core
package mem_pkg;
    localparam logic [1:0] MEM_OP_IDLE  = 2'b00;
    localparam logic [1:0] MEM_OP_READ  = 2'b01;
    localparam logic [1:0] MEM_OP_WRITE = 2'b10;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first pending index after last_grant
module rr_pick #(
    parameter int REQ_BIT = 1
) (
    input  logic [(1<<REQ_BIT)-1:0] pending,
    input  logic [REQ_BIT-1:0]      last_grant,
    output logic                    valid,
    output logic [REQ_BIT-1:0]      index
);
    localparam int N = 1 << REQ_BIT;
    logic [REQ_BIT-1:0] c;
    always_comb begin
        valid = |pending;
        index = '0;
        c = '0;
        for (int k = N; k >= 1; k--) begin
            c = last_grant + k[REQ_BIT-1:0];
            if (pending[c]) index = c;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-outstanding memory port between 1<<REQ_BIT requesters
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int REQ_BIT  = 1,
    parameter int ADDR_BIT = 32,
    parameter int DATA_BIT = 32
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [2*(1<<REQ_BIT)-1:0]           req_rw_flag,
    input  logic [ADDR_BIT*(1<<REQ_BIT)-1:0]    req_addr,
    input  logic [DATA_BIT*(1<<REQ_BIT)-1:0]    req_write_data,
    input  logic [(DATA_BIT/8)*(1<<REQ_BIT)-1:0] req_write_mask,
    output logic [DATA_BIT*(1<<REQ_BIT)-1:0]    req_read_data,
    output logic [(1<<REQ_BIT)-1:0]             req_busy,
    output logic [(1<<REQ_BIT)-1:0]             req_done,
    output logic [1:0]                          mem_rw_flag,
    output logic [ADDR_BIT-1:0]                 mem_addr,
    output logic [DATA_BIT-1:0]                 mem_write_data,
    output logic [DATA_BIT/8-1:0]               mem_write_mask,
    input  logic [DATA_BIT-1:0]                 mem_read_data,
    input  logic                                mem_busy,
    input  logic                                mem_done
);
    localparam int N        = 1 << REQ_BIT;
    localparam int MASK_BIT = DATA_BIT / 8;
    arb_state_t         state;
    logic [1:0]         op;
    logic [REQ_BIT-1:0] grant, last_grant, pick_index;
    logic [N-1:0]       pending;
    logic               pick_valid;
    // 01 and 10 are the only legal ops, so the xor of the pair drops both idle and illegal
    for (genvar i = 0; i < N; i++) assign pending[i] = ^req_rw_flag[2*i +: 2];
    rr_pick #(.REQ_BIT(REQ_BIT)) u_pick (
        .pending    (pending),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .index      (pick_index)
    );
    assign mem_rw_flag = state == ISSUE ? op : MEM_OP_IDLE;
    assign req_busy    = {N{state != IDLE}};
    always_comb begin
        req_done = '0;
        req_done[grant] = state == DONE;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            op             <= MEM_OP_IDLE;
            grant          <= '0;
            last_grant     <= '1;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_write_mask <= '0;
            req_read_data  <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    op             <= req_rw_flag[2*pick_index +: 2];
                    mem_addr       <= req_addr[ADDR_BIT*pick_index +: ADDR_BIT];
                    mem_write_data <= req_write_data[DATA_BIT*pick_index +: DATA_BIT];
                    mem_write_mask <= req_write_mask[MASK_BIT*pick_index +: MASK_BIT];
                    grant          <= pick_index;
                    last_grant     <= pick_index;
                    state          <= ISSUE;
                end
                ISSUE: if (!mem_busy) state <= WAIT;
                WAIT: if (mem_done) begin
                    if (op == MEM_OP_READ) req_read_data[DATA_BIT*grant +: DATA_BIT] <= mem_read_data;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, backpressure, completion routing and reset
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_rw_flag = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_write_data = '0;
    logic [7:0]  req_write_mask = '0;
    logic [63:0] req_read_data;
    logic [1:0]  req_busy, req_done, mem_rw_flag;
    logic [31:0] mem_addr, mem_write_data;
    logic [3:0]  mem_write_mask;
    logic [31:0] mem_read_data = '0;
    logic        mem_busy = 1'b0;
    logic        mem_done = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;
    mem_port_arbiter #(.REQ_BIT(1), .ADDR_BIT(32), .DATA_BIT(32)) dut (
        .CLK            (clk),
        .RST            (rst),
        .req_rw_flag    (req_rw_flag),
        .req_addr       (req_addr),
        .req_write_data (req_write_data),
        .req_write_mask (req_write_mask),
        .req_read_data  (req_read_data),
        .req_busy       (req_busy),
        .req_done       (req_done),
        .mem_rw_flag    (mem_rw_flag),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write_mask (mem_write_mask),
        .mem_read_data  (mem_read_data),
        .mem_busy       (mem_busy),
        .mem_done       (mem_done)
    );
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic all_zero(input string tag);
        chk({tag, "_rdata"}, req_read_data, 64'h0);
        chk({tag, "_busy"}, {62'h0, req_busy}, 64'h0);
        chk({tag, "_done"}, {62'h0, req_done}, 64'h0);
        chk({tag, "_flag"}, {62'h0, mem_rw_flag}, 64'h0);
        chk({tag, "_addr"}, {32'h0, mem_addr}, 64'h0);
        chk({tag, "_wdata"}, {32'h0, mem_write_data}, 64'h0);
        chk({tag, "_mask"}, {60'h0, mem_write_mask}, 64'h0);
    endtask
    initial begin
        step;
        all_zero("reset");
        rst = 1'b0;
        // single read by requester 0, done 3 cycles after acceptance
        req_rw_flag = 4'b0001;
        req_addr = {32'h0, 32'h0000_1000};
        step;
        chk("rd_flag", mem_rw_flag, 2'b01);
        chk("rd_addr", mem_addr, 32'h0000_1000);
        chk("rd_busy", req_busy, 2'b11);
        step;
        chk("rd_flag_once", mem_rw_flag, 2'b00);
        step;
        chk("rd_nodone", req_done, 2'b00);
        mem_read_data = 32'hDEADBEEF;
        mem_done = 1'b1;
        step;
        mem_done = 1'b0;
        chk("rd_done", req_done, 2'b01);
        chk("rd_data", req_read_data, 64'h0000_0000_DEADBEEF);
        req_rw_flag = 4'b0000;
        step;
        chk("rd_done_pulse", req_done, 2'b00);
        chk("rd_idle_busy", req_busy, 2'b00);
        // contention after reset: both requesting continuously, 0 wins first
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("cont_reset_rdata", req_read_data, 64'h0);
        req_rw_flag = 4'b1001;
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_write_data = {32'hCAFE_0001, 32'h0};
        req_write_mask = 8'hF0;
        for (int k = 0; k < 6; k++) begin
            step;
            chk($sformatf("cont%0d_addr", k), mem_addr, (k % 2) ? 32'h200 : 32'h100);
            chk($sformatf("cont%0d_flag", k), mem_rw_flag, (k % 2) ? 2'b10 : 2'b01);
            step;
            mem_read_data = 32'hA0 + k;
            mem_done = 1'b1;
            step;
            mem_done = 1'b0;
            chk($sformatf("cont%0d_done", k), req_done, (k % 2) ? 2'b10 : 2'b01);
            step;
        end
        chk("cont_rdata", req_read_data, 64'h0000_0000_0000_00A4);
        chk("cont_wdata", mem_write_data, 32'hCAFE_0001);
        req_rw_flag = 4'b0000;
        step;
        // backpressure on a write from requester 0
        req_rw_flag = 4'b0010;
        req_addr = {32'h0000_0200, 32'h0000_0020};
        req_write_data = {32'hCAFE_0001, 32'h1234_5678};
        req_write_mask = 8'hF3;
        mem_busy = 1'b1;
        step;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp%0d_flag", i), mem_rw_flag, 2'b10);
            chk($sformatf("bp%0d_addr", i), mem_addr, 32'h20);
            chk($sformatf("bp%0d_data", i), mem_write_data, 32'h1234_5678);
            chk($sformatf("bp%0d_mask", i), mem_write_mask, 4'b0011);
            if (i == 5) mem_busy = 1'b0;
            step;
        end
        chk("bp_accept", mem_rw_flag, 2'b00);
        mem_read_data = 32'h5A5A_5A5A;
        mem_done = 1'b1;
        step;
        mem_done = 1'b0;
        chk("bp_done", req_done, 2'b01);
        chk("bp_rdata", req_read_data, 64'h0000_0000_0000_00A4);
        req_rw_flag = 4'b0000;
        step;
        // spurious mem_done in IDLE and illegal op from requester 1
        req_rw_flag = 4'b1100;
        mem_done = 1'b1;
        step;
        mem_done = 1'b0;
        chk("sp_done", req_done, 2'b00);
        chk("sp_busy", req_busy, 2'b00);
        chk("sp_flag", mem_rw_flag, 2'b00);
        step;
        chk("sp_done2", req_done, 2'b00);
        chk("sp_busy2", req_busy, 2'b00);
        req_rw_flag = 4'b1101;
        req_addr = {32'h0000_0200, 32'h0000_0044};
        step;
        chk("il_flag", mem_rw_flag, 2'b01);
        chk("il_addr", mem_addr, 32'h44);
        step;
        mem_read_data = 32'h0000_0055;
        mem_done = 1'b1;
        step;
        mem_done = 1'b0;
        chk("il_done", req_done, 2'b01);
        chk("il_rdata", req_read_data, 64'h0000_0000_0000_0055);
        req_rw_flag = 4'b1100;
        step;
        chk("il_nogrant", req_busy, 2'b00);
        // asynchronous reset during WAIT
        req_rw_flag = 4'b0001;
        step;
        step;
        chk("rw_wait_busy", req_busy, 2'b11);
        #2 rst = 1'b1;
        #1;
        all_zero("async");
        req_rw_flag = 4'b0101;
        req_addr = {32'h0000_0300, 32'h0000_0100};
        step;
        chk("rw_held", req_busy, 2'b00);
        rst = 1'b0;
        step;
        chk("rw_first_addr", mem_addr, 32'h100);
        chk("rw_first_flag", mem_rw_flag, 2'b01);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
